// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_store_unit_pkg                                        |
// | Description : Shared definitions for the load/store unit: Funct3 access  |
// |               encodings, FSM state enum, and helpers for access          |
// |               legality and byte-enable generation.                       |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package load_store_unit_pkg;

   // Load encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } lsu_state_e;

   // True when the size encoding exists for this direction and the
   // address is naturally aligned for that size.
   function automatic logic access_ok(input logic       we,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
      logic ok;
      ok = 1'b0;
      if (we) begin
         case (f3)
            F3_SB:   ok = 1'b1;
            F3_SH:   ok = ~off[0];
            F3_SW:   ok = (off == 2'b00);
            default: ok = 1'b0;
         endcase
      end else begin
         case (f3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~off[0];
            F3_LW:         ok = (off == 2'b00);
            default:       ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   // Size is carried in f3[1:0] for both signed and unsigned variants.
   function automatic logic [3:0] byte_enables(input logic [2:0] f3,
                                               input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_store_unit_if                                         |
// | Description : Memory bus between the load/store unit (master) and the    |
// |               data memory (slave). Request channel is valid/ready;       |
// |               read response is a single valid-qualified word.            |
// | Signals     : MemReqValid  request valid        (master -> slave)        |
// |               MemReqReady  request accepted     (slave  -> master)       |
// |               MemAddr      word-aligned address (master -> slave)        |
// |               MemWData     lane-replicated data (master -> slave)        |
// |               MemBE        byte enables         (master -> slave)        |
// |               MemWE        1 = write            (master -> slave)        |
// |               MemRspValid  read data valid      (slave  -> master)       |
// |               MemRData     read word            (slave  -> master)       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface load_store_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  MemReqValid;
   logic                  MemReqReady;
   logic [DATA_WIDTH-1:0] MemAddr;
   logic [DATA_WIDTH-1:0] MemWData;
   logic [3:0]            MemBE;
   logic                  MemWE;
   logic                  MemRspValid;
   logic [DATA_WIDTH-1:0] MemRData;

   modport master (
      output MemReqValid, MemAddr, MemWData, MemBE, MemWE,
      input  MemReqReady, MemRspValid, MemRData
   );

   modport slave (
      input  MemReqValid, MemAddr, MemWData, MemBE, MemWE,
      output MemReqReady, MemRspValid, MemRData
   );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_extend                                                |
// | Description : Combinational load formatter. Picks the addressed byte or  |
// |               halfword lane out of the read word and sign- or zero-      |
// |               extends it according to the load encoding.                 |
// | Ports       : rdata_i   read word from memory                            |
// |               offset_i  byte offset within the word (addr[1:0])          |
// |               funct3_i  load size/sign encoding                          |
// |               result_o  extended load result                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module load_extend
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic [1:0]            offset_i,
   input  logic [2:0]            funct3_i,
   output logic [DATA_WIDTH-1:0] result_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Halfword accesses are aligned, so only offset[1] picks the lane.
   assign w_byte = rdata_i[{offset_i, 3'b000} +: 8];
   assign w_half = rdata_i[{offset_i[1], 4'b0000} +: 16];

   always_comb begin
      result_o = rdata_i;
      case (funct3_i)
         F3_LB:   result_o = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
         F3_LH:   result_o = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
         F3_LBU:  result_o = {{(DATA_WIDTH-8){1'b0}}, w_byte};
         F3_LHU:  result_o = {{(DATA_WIDTH-16){1'b0}}, w_half};
         default: result_o = rdata_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_store_unit                                            |
// | Description : Memory-stage load/store unit. Accepts one access from      |
// |               execute, checks alignment/encoding, issues one bus         |
// |               request, waits for read data on loads and returns the      |
// |               extended result. Upstream is stalled while busy.           |
// | Ports       : clk_i, rst_ni        clock, async active-low reset         |
// |               MemReqE_i            execute presents an access            |
// |               MemWriteE_i          1 = store, 0 = load                   |
// |               Funct3E_i            size/sign encoding                    |
// |               ALUResultE_i         byte address                          |
// |               WriteDataE_i         unshifted store data                  |
// |               RdE_i                load destination register             |
// |               mem                  memory bus (master modport)           |
// |               StallM_o             freeze upstream pipeline              |
// |               ReadDataM_o, RdM_o   load result and destination           |
// |               LoadValidM_o         one-cycle load completion pulse       |
// |               ExcM_o               one-cycle misaligned/illegal pulse    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,

   input  logic                  MemReqE_i,
   input  logic                  MemWriteE_i,
   input  logic [2:0]            Funct3E_i,
   input  logic [DATA_WIDTH-1:0] ALUResultE_i,
   input  logic [DATA_WIDTH-1:0] WriteDataE_i,
   input  logic [4:0]            RdE_i,

   load_store_unit_if.master     mem,

   output logic                  StallM_o,
   output logic [DATA_WIDTH-1:0] ReadDataM_o,
   output logic [4:0]            RdM_o,
   output logic                  LoadValidM_o,
   output logic                  ExcM_o
);

   lsu_state_e            state_q, state_d;

   // Captured transaction
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [3:0]            be_q;
   logic                  we_q;
   logic [2:0]            funct3_q;
   logic [4:0]            rd_q;

   // Result registers
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [4:0]            rdm_q;
   logic                  load_valid_q, load_valid_d;
   logic                  exc_q, exc_d;

   logic                  w_access_ok;
   logic                  w_capture;
   logic [DATA_WIDTH-1:0] w_store_data;
   logic [DATA_WIDTH-1:0] w_load_result;

   assign w_access_ok = access_ok(MemWriteE_i, Funct3E_i, ALUResultE_i[1:0]);

   // Replicate the store data across every lane so the byte enables alone
   // select what the memory writes.
   always_comb begin
      w_store_data = WriteDataE_i;
      case (Funct3E_i[1:0])
         2'b00:   w_store_data = {(DATA_WIDTH/8){WriteDataE_i[7:0]}};
         2'b01:   w_store_data = {(DATA_WIDTH/16){WriteDataE_i[15:0]}};
         default: w_store_data = WriteDataE_i;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      w_capture    = 1'b0;
      exc_d        = 1'b0;
      load_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (MemReqE_i) begin
               if (w_access_ok) begin
                  w_capture = 1'b1;
                  state_d   = ST_REQ;
               end else begin
                  exc_d = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (mem.MemReqReady) begin
               state_d = we_q ? ST_IDLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem.MemRspValid) begin
               load_valid_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Transaction capture and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         we_q         <= 1'b0;
         funct3_q     <= '0;
         rd_q         <= '0;
         rdata_q      <= '0;
         rdm_q        <= '0;
         load_valid_q <= 1'b0;
         exc_q        <= 1'b0;
      end else begin
         load_valid_q <= load_valid_d;
         exc_q        <= exc_d;
         if (w_capture) begin
            addr_q   <= ALUResultE_i;
            wdata_q  <= w_store_data;
            be_q     <= byte_enables(Funct3E_i, ALUResultE_i[1:0]);
            we_q     <= MemWriteE_i;
            funct3_q <= Funct3E_i;
            rd_q     <= RdE_i;
         end
         if (load_valid_d) begin
            rdata_q <= w_load_result;
            rdm_q   <= rd_q;
         end
      end
   end

   load_extend #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_extend (
      .rdata_i  (mem.MemRData),
      .offset_i (addr_q[1:0]),
      .funct3_i (funct3_q),
      .result_o (w_load_result)
   );

   // ------------------------------------------------------------------
   // Outputs: all decoded from registered state
   // ------------------------------------------------------------------
   assign mem.MemReqValid = (state_q == ST_REQ);
   assign mem.MemAddr     = {addr_q[DATA_WIDTH-1:2], 2'b00};
   assign mem.MemWData    = wdata_q;
   assign mem.MemBE       = be_q;
   assign mem.MemWE       = we_q;

   assign StallM_o     = (state_q != ST_IDLE);
   assign ReadDataM_o  = rdata_q;
   assign RdM_o        = rdm_q;
   assign LoadValidM_o = load_valid_q;
   assign ExcM_o       = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                         |
// | Description : Self-checking bench for load_store_unit. A vector table    |
// |               drives single accesses; load results go through a          |
// |               scoreboard queue checked by a completion monitor. Hand-    |
// |               written sequences cover reset mid-load and a held request. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        MemReqE;
   logic        MemWriteE;
   logic [2:0]  Funct3E;
   logic [31:0] ALUResultE;
   logic [31:0] WriteDataE;
   logic [4:0]  RdE;
   logic        StallM;
   logic [31:0] ReadDataM;
   logic [4:0]  RdM;
   logic        LoadValidM;
   logic        ExcM;

   int checks = 0;
   int errors = 0;

   load_store_unit_if #(.DATA_WIDTH(32)) bus ();

   load_store_unit #(.DATA_WIDTH(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .MemReqE_i    (MemReqE),
      .MemWriteE_i  (MemWriteE),
      .Funct3E_i    (Funct3E),
      .ALUResultE_i (ALUResultE),
      .WriteDataE_i (WriteDataE),
      .RdE_i        (RdE),
      .mem          (bus),
      .StallM_o     (StallM),
      .ReadDataM_o  (ReadDataM),
      .RdM_o        (RdM),
      .LoadValidM_o (LoadValidM),
      .ExcM_o       (ExcM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [4:0]  rd;
      int          rsp_delay;
      logic        exp_exc;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_addr;
      logic [31:0] exp_result;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
   } sb_t;

   sb_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input logic [4:0] rd, input int d, input logic exc,
                               input logic [3:0] be, input logic [31:0] ewd,
                               input logic [31:0] eaddr, input logic [31:0] eres);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.rd = rd; v.rsp_delay = d; v.exp_exc = exc; v.exp_be = be;
      v.exp_wdata = ewd; v.exp_addr = eaddr; v.exp_result = eres;
      return v;
   endfunction

   // Completion monitor: every load result must match the oldest expectation.
   always @(negedge clk) begin
      if (LoadValidM) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load_valid: got LoadValidM=1 expected 0 at %0t", $time);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("load_data", ReadDataM, e.data);
            chk("load_rd", {27'd0, RdM}, {27'd0, e.rd});
         end
      end
   end

   // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
   task automatic run_vec(input vec_t v);
      sb_t e;
      MemReqE    = 1'b1;
      MemWriteE  = v.we;
      Funct3E    = v.f3;
      ALUResultE = v.addr;
      WriteDataE = v.wdata;
      RdE        = v.rd;
      @(negedge clk);
      MemReqE = 1'b0;
      if (v.exp_exc) begin
         chk("exc_pulse", {31'd0, ExcM}, 32'd1);
         chk("exc_no_req", {31'd0, bus.MemReqValid}, 32'd0);
         chk("exc_no_stall", {31'd0, StallM}, 32'd0);
         @(negedge clk);
         chk("exc_width", {31'd0, ExcM}, 32'd0);
         chk("exc_no_req2", {31'd0, bus.MemReqValid}, 32'd0);
         chk("exc_no_stall2", {31'd0, StallM}, 32'd0);
      end else begin
         chk("req_valid", {31'd0, bus.MemReqValid}, 32'd1);
         chk("req_stall", {31'd0, StallM}, 32'd1);
         chk("req_addr", bus.MemAddr, v.exp_addr);
         chk("req_be", {28'd0, bus.MemBE}, {28'd0, v.exp_be});
         chk("req_we", {31'd0, bus.MemWE}, {31'd0, v.we});
         if (v.we) chk("req_wdata", bus.MemWData, v.exp_wdata);
         if (!v.we) begin
            e.data = v.exp_result;
            e.rd   = v.rd;
            sb_q.push_back(e);
         end
         bus.MemReqReady = 1'b1;
         @(negedge clk);
         bus.MemReqReady = 1'b0;
         chk("req_drop", {31'd0, bus.MemReqValid}, 32'd0);
         if (v.we) begin
            chk("store_stall_end", {31'd0, StallM}, 32'd0);
         end else begin
            for (int i = 1; i <= v.rsp_delay; i++) begin
               chk("wait_stall", {31'd0, StallM}, 32'd1);
               if (i == v.rsp_delay) begin
                  bus.MemRspValid = 1'b1;
                  bus.MemRData    = v.rdata;
               end
               @(negedge clk);
            end
            bus.MemRspValid = 1'b0;
            bus.MemRData    = 32'hBAD0_BAD0;
            chk("load_stall_end", {31'd0, StallM}, 32'd0);
            chk("load_valid", {31'd0, LoadValidM}, 32'd1);
            @(negedge clk);
            chk("load_valid_width", {31'd0, LoadValidM}, 32'd0);
            chk("load_data_hold", ReadDataM, v.exp_result);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_stall"}, {31'd0, StallM}, 32'd0);
      chk({tag, "_valid"}, {31'd0, bus.MemReqValid}, 32'd0);
      chk({tag, "_addr"}, bus.MemAddr, 32'd0);
      chk({tag, "_wdata"}, bus.MemWData, 32'd0);
      chk({tag, "_be"}, {28'd0, bus.MemBE}, 32'd0);
      chk({tag, "_we"}, {31'd0, bus.MemWE}, 32'd0);
      chk({tag, "_rdata"}, ReadDataM, 32'd0);
      chk({tag, "_rd"}, {27'd0, RdM}, 32'd0);
      chk({tag, "_ldv"}, {31'd0, LoadValidM}, 32'd0);
      chk({tag, "_exc"}, {31'd0, ExcM}, 32'd0);
   endtask

   vec_t vecs[16];

   initial begin
      //              we    f3      addr          wdata         rdata         rd  d  exc  be       exp_wdata     exp_addr      exp_result
      vecs[0]  = mk(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        5'd0, 0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0);
      vecs[1]  = mk(1'b0, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF_1234, 5'd5, 3, 1'b0, 4'b1000, 32'h0,        32'h0000_0200, 32'hFFFF_FF80);
      vecs[2]  = mk(1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h80FF_1234, 5'd6, 3, 1'b0, 4'b1000, 32'h0,        32'h0000_0200, 32'h0000_0080);
      vecs[3]  = mk(1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 32'h0,        5'd0, 0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0010, 32'h0);
      vecs[4]  = mk(1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        5'd1, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0);
      vecs[5]  = mk(1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'h80FF_1234, 5'd9, 1, 1'b0, 4'b1100, 32'h0,        32'h0000_0200, 32'hFFFF_80FF);
      vecs[6]  = mk(1'b0, 3'b101, 32'h0000_0200, 32'h0,        32'h80FF_9234, 5'd10, 2, 1'b0, 4'b0011, 32'h0,       32'h0000_0200, 32'h0000_9234);
      vecs[7]  = mk(1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'hCAFE_F00D, 5'd31, 1, 1'b0, 4'b1111, 32'h0,       32'h0000_0300, 32'hCAFE_F00D);
      vecs[8]  = mk(1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5, 32'h0,        5'd0, 0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0100, 32'h0);
      vecs[9]  = mk(1'b0, 3'b000, 32'h0000_0401, 32'h0,        32'h0000_7F00, 5'd12, 2, 1'b0, 4'b0010, 32'h0,       32'h0000_0400, 32'h0000_007F);
      vecs[10] = mk(1'b1, 3'b001, 32'h0000_0013, 32'h0000_1111, 32'h0,        5'd0, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0);
      vecs[11] = mk(1'b1, 3'b100, 32'h0000_0020, 32'h0000_2222, 32'h0,        5'd0, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0);
      vecs[12] = mk(1'b0, 3'b011, 32'h0000_0020, 32'h0,        32'h0,        5'd3, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0);
      vecs[13] = mk(1'b1, 3'b010, 32'h0000_0102, 32'h0000_3333, 32'h0,        5'd0, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0);
      vecs[14] = mk(1'b0, 3'b101, 32'h0000_0005, 32'h0,        32'h0,        5'd4, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0);
      vecs[15] = mk(1'b1, 3'b000, 32'h0000_0043, 32'h0000_00C3, 32'h0,        5'd0, 0, 1'b0, 4'b1000, 32'hC3C3_C3C3, 32'h0000_0040, 32'h0);

      rst_n           = 1'b0;
      MemReqE         = 1'b0;
      MemWriteE       = 1'b0;
      Funct3E         = 3'b000;
      ALUResultE      = 32'h0;
      WriteDataE      = 32'h0;
      RdE             = 5'd0;
      bus.MemReqReady = 1'b0;
      bus.MemRspValid = 1'b0;
      bus.MemRData    = 32'hBAD0_BAD0;

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) run_vec(vecs[i]);

      // Request held with ready low: bus fields stable, new request ignored.
      MemReqE    = 1'b1;
      MemWriteE  = 1'b1;
      Funct3E    = 3'b010;
      ALUResultE = 32'h0000_0040;
      WriteDataE = 32'h1234_5678;
      RdE        = 5'd0;
      @(negedge clk);
      MemReqE = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", {31'd0, bus.MemReqValid}, 32'd1);
         chk("hold_stall", {31'd0, StallM}, 32'd1);
         chk("hold_addr", bus.MemAddr, 32'h0000_0040);
         chk("hold_wdata", bus.MemWData, 32'h1234_5678);
         chk("hold_be", {28'd0, bus.MemBE}, 32'h0000_000F);
         chk("hold_we", {31'd0, bus.MemWE}, 32'd1);
         if (i == 1) begin
            MemReqE    = 1'b1;
            MemWriteE  = 1'b0;
            Funct3E    = 3'b000;
            ALUResultE = 32'h0000_0081;
            RdE        = 5'd7;
         end
         if (i == 2) MemReqE = 1'b0;
         @(negedge clk);
      end
      bus.MemReqReady = 1'b1;
      @(negedge clk);
      bus.MemReqReady = 1'b0;
      chk("hold_done_valid", {31'd0, bus.MemReqValid}, 32'd0);
      chk("hold_done_stall", {31'd0, StallM}, 32'd0);
      @(negedge clk);
      chk("hold_ignored_valid", {31'd0, bus.MemReqValid}, 32'd0);
      chk("hold_ignored_stall", {31'd0, StallM}, 32'd0);

      // Response while idle must not produce a load result.
      bus.MemRspValid = 1'b1;
      bus.MemRData    = 32'h5555_5555;
      @(negedge clk);
      bus.MemRspValid = 1'b0;
      chk("idle_rsp_ldv", {31'd0, LoadValidM}, 32'd0);
      chk("idle_rsp_stall", {31'd0, StallM}, 32'd0);

      // Reset while waiting for read data.
      MemReqE    = 1'b1;
      MemWriteE  = 1'b0;
      Funct3E    = 3'b010;
      ALUResultE = 32'h0000_0500;
      RdE        = 5'd7;
      @(negedge clk);
      MemReqE         = 1'b0;
      bus.MemReqReady = 1'b1;
      @(negedge clk);
      bus.MemReqReady = 1'b0;
      chk("rst_wait_stall", {31'd0, StallM}, 32'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrst");
      @(negedge clk);
      rst_n           = 1'b1;
      bus.MemRspValid = 1'b1;
      bus.MemRData    = 32'h1111_1111;
      @(negedge clk);
      bus.MemRspValid = 1'b0;
      bus.MemRData    = 32'hBAD0_BAD0;
      chk("postrst_ldv", {31'd0, LoadValidM}, 32'd0);
      chk("postrst_rdata", ReadDataM, 32'd0);
      chk("postrst_stall", {31'd0, StallM}, 32'd0);
      @(negedge clk);
      chk("postrst_ldv2", {31'd0, LoadValidM}, 32'd0);

      run_vec(mk(1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 5'd8, 1, 1'b0,
                 4'b1111, 32'h0, 32'h0000_0600, 32'h0BAD_F00D));

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of address and data paths.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-004 MemReqE_i  in  1  execute presents a load/store this cycle.
REQ-005 MemWriteE_i  in  1  1 = store, 0 = load.
REQ-006 Funct3E_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUResultE_i  in  DATA_WIDTH  byte address.
REQ-008 WriteDataE_i  in  DATA_WIDTH  store data, unshifted.
REQ-009 RdE_i  in  5  load destination register.
REQ-010 MemReqValid_o  out  1  bus request valid.
REQ-011 MemReqReady_i  in  1  bus accepts request.
REQ-012 MemAddr_o  out  DATA_WIDTH  word-aligned address, {addr[31:2],2'b00}.
REQ-013 MemWData_o  out  DATA_WIDTH  lane-replicated store data.
REQ-014 MemBE_o  out  4  byte enables.
REQ-015 MemWE_o  out  1  1 = write.
REQ-016 MemRspValid_i  in  1  read data valid.
REQ-017 MemRData_i  in  DATA_WIDTH  read word.
REQ-018 StallM_o  out  1  freeze upstream pipeline.
REQ-019 ReadDataM_o  out  DATA_WIDTH  extended load result.
REQ-020 RdM_o  out  5  load destination.
REQ-021 LoadValidM_o  out  1  one-cycle pulse, ReadDataM_o/RdM_o valid.
REQ-022 ExcM_o  out  1  one-cycle pulse, misaligned or illegal Funct3.

Function
REQ-023 FSM states IDLE, REQ, WAIT; StallM_o = (state != IDLE), registered-state decode only.
REQ-024 IDLE: MemReqE_i with legal, aligned access captures addr/data/funct3/rd/we into registers, next state REQ.
REQ-025 IDLE: MemReqE_i with H/HU and addr[0]=1, W and addr[1:0]!=0, or Funct3 in {011,110,111} (stores: only 000/001/010 legal) -> ExcM_o pulses next cycle, no bus access, stay IDLE.
REQ-026 MemReqE_i while state != IDLE ignored (upstream holds under stall).
REQ-027 REQ: MemReqValid_o=1 with stable registered bus fields until MemReqReady_i; on handshake store -> IDLE, load -> WAIT.
REQ-028 WAIT: on MemRspValid_i select lane by captured addr[1:0], sign-extend (B/H) or zero-extend (BU/HU), register into ReadDataM_o, RdM_o, pulse LoadValidM_o, -> IDLE.
REQ-029 MemRspValid_i outside WAIT ignored; MemReqReady_i outside REQ ignored.
REQ-030 Byte enables: B 4'b0001<<addr[1:0], H 4'b0011<<addr[1:0], W 4'b1111; loads also drive MemBE_o per size.
REQ-031 Store data: B {4{wd[7:0]}}, H {2{wd[15:0]}}, W wd.
REQ-032 Latency with ready/rsp at earliest: store 1 cycle stalled; load 2 cycles stalled, result visible the edge leaving WAIT.
REQ-033 ReadDataM_o/RdM_o hold value between loads; LoadValidM_o and ExcM_o high exactly one cycle.

Reset
REQ-034 rst_ni low forces IDLE immediately; all outputs and captured registers 0, any in-flight transaction abandoned.
REQ-035 Response arriving after mid-transaction reset is ignored (state IDLE).

Structure
REQ-036 Shared package holds Funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW) and the FSM state enum.
REQ-037 One combinational sub-module load_extend (rdata, addr[1:0], funct3 -> extended result) instantiated once.

Verification
REQ-038 SW addr 0x100, data 0xDEADBEEF, ready held high -> one REQ cycle, BE 1111, WE 1, addr 0x100, StallM_o high 1 cycle.
REQ-039 LB addr 0x203, rdata 0x80FF1234, ready immediate, rsp 3 cycles later -> ReadDataM_o 0xFFFFFF80, LoadValidM_o one pulse, stall 4 cycles; LBU same -> 0x00000080.
REQ-040 SH addr 0x12, data 0x0000ABCD -> BE 1100, WData 0xABCDABCD, addr 0x10.
REQ-041 LW addr 0x6 -> ExcM_o one pulse, MemReqValid_o never asserted, StallM_o stays 0.
REQ-042 Load in WAIT, rst_ni pulsed low, then MemRspValid_i -> no LoadValidM_o, all outputs 0, next LW accepted normally.
REQ-043 REQ with ready low 5 cycles -> MemReqValid_o and bus fields stable all 5 cycles, second MemReqE_i ignored.
